// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged multi-domain reset release gated by synchronised clock lock
module reset_sequencer_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

module reset_sequencer #(
    parameter int N_CH          = 3,
    parameter int STABLE_CYCLES = 16,
    parameter int STAGE_GAP     = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            locked,
    input  logic            ext_rst_req,
    output logic [N_CH-1:0] reset_out,
    output logic            seq_done,
    output logic [1:0]      state,
    output logic [7:0]      lock_loss_cnt
);

    localparam logic [1:0] HOLD    = 2'b00;
    localparam logic [1:0] RELEASE = 2'b01;
    localparam logic [1:0] RUN     = 2'b10;

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [SW-1:0]   STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [GW-1:0]   GAP_LAST    = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0]   LAST_IDX    = IW'(N_CH - 1);
    localparam logic [N_CH-1:0] CH0_ONLY    = N_CH'(1);

    logic            locked_s;
    logic            req_s;
    logic            ok;
    logic [SW-1:0]   stable_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [IW-1:0]   rel_idx;
    logic [N_CH-1:0] chan_mask;

    reset_sequencer_sync #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (locked),
        .dout (locked_s)
    );

    reset_sequencer_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ext_rst_req),
        .dout (req_s)
    );

    assign ok = locked_s & ~req_s;

    // One-hot select of the channel to release next (rel_idx).
    always_comb begin
        chan_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            chan_mask[i] = (rel_idx == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reset_out     <= '1;
            seq_done      <= 1'b0;
            state         <= HOLD;
            lock_loss_cnt <= 8'd0;
            stable_cnt    <= '0;
            gap_cnt       <= '0;
            rel_idx       <= '0;
        end else begin
            case (state)
                HOLD: begin
                    reset_out <= '1;
                    seq_done  <= 1'b0;
                    gap_cnt   <= '0;
                    rel_idx   <= '0;
                    if (!ok) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        stable_cnt <= '0;
                        if (N_CH == 1) begin
                            reset_out <= '0;
                            seq_done  <= 1'b1;
                            state     <= RUN;
                        end else begin
                            reset_out <= ~CH0_ONLY;
                            rel_idx   <= IW'(1);
                            state     <= RELEASE;
                        end
                    end else begin
                        stable_cnt <= stable_cnt + SW'(1);
                    end
                end

                RELEASE, RUN: begin
                    if (!ok) begin
                        // Abort: every domain back into reset at once.
                        reset_out  <= '1;
                        seq_done   <= 1'b0;
                        state      <= HOLD;
                        stable_cnt <= '0;
                        gap_cnt    <= '0;
                        rel_idx    <= '0;
                        if (!locked_s && (lock_loss_cnt != 8'hFF)) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                    end else if (state == RUN) begin
                        reset_out <= '0;
                        seq_done  <= 1'b1;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        reset_out <= reset_out & ~chan_mask;
                        rel_idx   <= rel_idx + IW'(1);
                        if (rel_idx == LAST_IDX) begin
                            seq_done <= 1'b1;
                            state    <= RUN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: begin
                    reset_out  <= '1;
                    seq_done   <= 1'b0;
                    state      <= HOLD;
                    stable_cnt <= '0;
                    gap_cnt    <= '0;
                    rel_idx    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench: expected output transitions per edge, 3-channel and 1-channel builds
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       ext_rst_req;
    logic [2:0] reset_out;
    logic       seq_done;
    logic [1:0] state;
    logic [7:0] lock_loss_cnt;
    logic [0:0] reset_out1;
    logic       seq_done1;
    logic [1:0] state1;
    logic [7:0] lock_loss_cnt1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [13:0] val;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    reset_sequencer #(.N_CH(3), .STABLE_CYCLES(16), .STAGE_GAP(4), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .ext_rst_req  (ext_rst_req),
        .reset_out    (reset_out),
        .seq_done     (seq_done),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    reset_sequencer #(.N_CH(1), .STABLE_CYCLES(16), .STAGE_GAP(4), .SYNC_STAGES(2)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .ext_rst_req  (ext_rst_req),
        .reset_out    (reset_out1),
        .seq_done     (seq_done1),
        .state        (state1),
        .lock_loss_cnt(lock_loss_cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected transition of the 3-channel build; the 1-channel build
    // resets on the same edges and runs as soon as channel 0 is released.
    task automatic ev(input int c, input logic [2:0] r, input logic d,
                      input logic [1:0] s, input logic [7:0] n);
        ev_t e;
        e.cyc = c;
        e.val = {r, d, s, n};
        q0.push_back(e);
        if (r == 3'b111) begin
            e.val = {2'b00, 1'b1, 1'b0, 2'b00, n};
            q1.push_back(e);
        end else if (r == 3'b110) begin
            e.val = {2'b00, 1'b0, 1'b1, 2'b10, n};
            q1.push_back(e);
        end
    endtask

    task automatic to_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [13:0] prev0 = 'x;
    logic [13:0] prev1 = 'x;

    always @(negedge clk) begin
        logic [13:0] cur;
        ev_t e;
        cur = {reset_out, seq_done, state, lock_loss_cnt};
        if (cur !== prev0) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL n3_unexpected: cycle=%0d value=%h required no change", cyc, cur);
            end else begin
                e = q0.pop_front();
                if (e.cyc != cyc || e.val !== cur) begin
                    failures++;
                    $display("FAIL n3_event: cycle=%0d value=%h required cycle=%0d value=%h",
                             cyc, cur, e.cyc, e.val);
                end
            end
            prev0 = cur;
        end
    end

    always @(negedge clk) begin
        logic [13:0] cur;
        ev_t e;
        cur = {2'b00, reset_out1, seq_done1, state1, lock_loss_cnt1};
        if (cur !== prev1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL n1_unexpected: cycle=%0d value=%h required no change", cyc, cur);
            end else begin
                e = q1.pop_front();
                if (e.cyc != cyc || e.val !== cur) begin
                    failures++;
                    $display("FAIL n1_event: cycle=%0d value=%h required cycle=%0d value=%h",
                             cyc, cur, e.cyc, e.val);
                end
            end
            prev1 = cur;
        end
    end

    initial begin
        int e0;
        logic [7:0] n;
        rst_n       = 1'b0;
        locked      = 1'b0;
        ext_rst_req = 1'b0;
        ev(1, 3'b111, 1'b0, 2'b00, 8'd0);

        // Power-up: lock arrives while still in reset
        to_edge(2);
        locked = 1'b1;
        to_edge(5);
        rst_n = 1'b1;
        ev(23, 3'b110, 1'b0, 2'b01, 8'd0);
        ev(27, 3'b100, 1'b0, 2'b01, 8'd0);
        ev(31, 3'b000, 1'b1, 2'b10, 8'd0);

        // Lock loss in RUN, then relock
        to_edge(35);
        locked = 1'b0;
        ev(38, 3'b111, 1'b0, 2'b00, 8'd1);
        to_edge(40);
        locked = 1'b1;
        ev(58, 3'b110, 1'b0, 2'b01, 8'd1);
        ev(62, 3'b100, 1'b0, 2'b01, 8'd1);
        ev(66, 3'b000, 1'b1, 2'b10, 8'd1);

        // Lock glitch during the HOLD stability count
        to_edge(70);
        locked = 1'b0;
        ev(73, 3'b111, 1'b0, 2'b00, 8'd2);
        to_edge(75);
        locked = 1'b1;
        to_edge(86);
        locked = 1'b0;
        to_edge(87);
        locked = 1'b1;
        ev(105, 3'b110, 1'b0, 2'b01, 8'd2);
        ev(109, 3'b100, 1'b0, 2'b01, 8'd2);
        ev(113, 3'b000, 1'b1, 2'b10, 8'd2);

        // External request from RUN, then during RELEASE
        to_edge(115);
        ext_rst_req = 1'b1;
        ev(118, 3'b111, 1'b0, 2'b00, 8'd2);
        to_edge(118);
        ext_rst_req = 1'b0;
        ev(136, 3'b110, 1'b0, 2'b01, 8'd2);
        to_edge(137);
        ext_rst_req = 1'b1;
        ev(140, 3'b111, 1'b0, 2'b00, 8'd2);
        to_edge(140);
        ext_rst_req = 1'b0;
        ev(158, 3'b110, 1'b0, 2'b01, 8'd2);
        ev(162, 3'b100, 1'b0, 2'b01, 8'd2);

        // rst_n on the RELEASE->RUN edge wins
        ev(166, 3'b111, 1'b0, 2'b00, 8'd0);
        to_edge(165);
        rst_n = 1'b0;
        to_edge(167);
        rst_n = 1'b1;
        ev(185, 3'b110, 1'b0, 2'b01, 8'd0);
        ev(189, 3'b100, 1'b0, 2'b01, 8'd0);
        ev(193, 3'b000, 1'b1, 2'b10, 8'd0);

        // 300 lock losses from RUN: counter saturates at 255
        e0 = 196;
        for (int k = 1; k <= 300; k++) begin
            n = (k > 255) ? 8'd255 : 8'(k);
            to_edge(e0);
            locked = 1'b0;
            ev(e0 + 3, 3'b111, 1'b0, 2'b00, n);
            to_edge(e0 + 5);
            locked = 1'b1;
            ev(e0 + 23, 3'b110, 1'b0, 2'b01, n);
            ev(e0 + 27, 3'b100, 1'b0, 2'b01, n);
            ev(e0 + 31, 3'b000, 1'b1, 2'b10, n);
            e0 += 34;
        end
        to_edge(e0 + 5);

        checks++;
        if (q0.size() != 0) begin
            failures++;
            $display("FAIL n3_pending: outstanding=%0d required 0 next_cycle=%0d", q0.size(), q0[0].cyc);
        end
        checks++;
        if (q1.size() != 0) begin
            failures++;
            $display("FAIL n1_pending: outstanding=%0d required 0 next_cycle=%0d", q1.size(), q1[0].cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
